// File: rtl/sc_fifo_flags.sv
// Single-clock FIFO with registered count/flags, optional showahead read port
// and sticky overflow/underflow indicators.
module sc_fifo_flags #(
  parameter int DWIDTH           = 8,
  parameter int AWIDTH           = 4,
  parameter int SHOWAHEAD        = 0,
  parameter int ALMOST_FULL_VAL  = 12,
  parameter int ALMOST_EMPTY_VAL = 2
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic [DWIDTH-1:0] data_i,
  input  logic              wr_req_i,
  input  logic              rd_req_i,
  output logic [DWIDTH-1:0] q_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              almost_empty_o,
  output logic              almost_full_o,
  output logic [AWIDTH:0]   usedw_o,
  output logic              ovf_o,
  output logic              udf_o
);

  localparam int DEPTH = 2**AWIDTH;
  localparam logic [AWIDTH:0] DEPTH_W = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH:0] AF_W    = (AWIDTH+1)'(ALMOST_FULL_VAL);
  localparam logic [AWIDTH:0] AE_W    = (AWIDTH+1)'(ALMOST_EMPTY_VAL);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AWIDTH-1:0] wr_pntr, rd_pntr;
  logic              wr_en, rd_en;
  logic [AWIDTH:0]   usedw_next;

  // Acceptance uses the registered flags; nothing is accepted during reset.
  assign wr_en = wr_req_i & ~full_o  & ~srst_i;
  assign rd_en = rd_req_i & ~empty_o & ~srst_i;
  assign usedw_next = usedw_o + (AWIDTH+1)'(wr_en) - (AWIDTH+1)'(rd_en);

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_pntr] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wr_pntr        <= '0;
      rd_pntr        <= '0;
      usedw_o        <= '0;
      empty_o        <= 1'b1;
      full_o         <= 1'b0;
      almost_empty_o <= 1'b1;
      almost_full_o  <= 1'b0;
      ovf_o          <= 1'b0;
      udf_o          <= 1'b0;
    end else begin
      if (wr_en) wr_pntr <= wr_pntr + AWIDTH'(1);
      if (rd_en) rd_pntr <= rd_pntr + AWIDTH'(1);
      usedw_o        <= usedw_next;
      empty_o        <= (usedw_next == '0);
      full_o         <= (usedw_next == DEPTH_W);
      almost_full_o  <= (usedw_next >= AF_W);
      almost_empty_o <= (usedw_next <  AE_W);
      if (wr_req_i & full_o)  ovf_o <= 1'b1;
      if (rd_req_i & empty_o) udf_o <= 1'b1;
    end
  end

  generate
    if (SHOWAHEAD != 0) begin : g_sa
      // Head word is always presented; valid only while not empty.
      assign q_o = mem[rd_pntr];
    end else begin : g_norm
      logic [DWIDTH-1:0] q_r;
      always_ff @(posedge clk_i) begin
        if (srst_i)     q_r <= '0;
        else if (rd_en) q_r <= mem[rd_pntr];
      end
      assign q_o = q_r;
    end
  endgenerate

endmodule

// File: tb/tb_sc_fifo_flags.sv
// Drives a normal-mode and a showahead-mode FIFO with identical stimulus and
// checks both against a queue-based model of the FIFO's externally visible rules.
module tb_sc_fifo_flags;

  logic       clk = 1'b0;
  logic       srst, wr, rd;
  logic [7:0] din;

  logic [7:0] q_n, q_sa;
  logic       emp_n, full_n, ae_n, af_n, ovf_n, udf_n;
  logic       emp_s, full_s, ae_s, af_s, ovf_s, udf_s;
  logic [4:0] uw_n, uw_s;

  always #5 clk = ~clk;

  sc_fifo_flags #(.SHOWAHEAD(0)) u_norm (
    .clk_i(clk), .srst_i(srst), .data_i(din), .wr_req_i(wr), .rd_req_i(rd),
    .q_o(q_n), .empty_o(emp_n), .full_o(full_n), .almost_empty_o(ae_n),
    .almost_full_o(af_n), .usedw_o(uw_n), .ovf_o(ovf_n), .udf_o(udf_n));

  sc_fifo_flags #(.SHOWAHEAD(1)) u_sa (
    .clk_i(clk), .srst_i(srst), .data_i(din), .wr_req_i(wr), .rd_req_i(rd),
    .q_o(q_sa), .empty_o(emp_s), .full_o(full_s), .almost_empty_o(ae_s),
    .almost_full_o(af_s), .usedw_o(uw_s), .ovf_o(ovf_s), .udf_o(udf_s));

  int total = 0;
  int bad   = 0;

  logic [7:0] m_q[$];
  logic [7:0] m_qn = 8'h00;
  logic       m_ovf = 1'b0, m_udf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic w, input logic r, input logic [7:0] d, input logic rs);
    int n;
    bit was_full, was_empty;
    wr = w; rd = r; din = d; srst = rs;
    @(posedge clk);
    if (rs) begin
      m_q.delete();
      m_qn  = 8'h00;
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      was_full  = (m_q.size() == 16);
      was_empty = (m_q.size() == 0);
      if (w && was_full)  m_ovf = 1'b1;
      if (r && was_empty) m_udf = 1'b1;
      if (r && !was_empty) m_qn = m_q.pop_front();
      if (w && !was_full)  m_q.push_back(d);
    end
    #1;
    n = m_q.size();
    chk("usedw",  32'(uw_n),   32'(n));
    chk("empty",  32'(emp_n),  32'(n == 0));
    chk("full",   32'(full_n), 32'(n == 16));
    chk("afull",  32'(af_n),   32'(n >= 12));
    chk("aempty", 32'(ae_n),   32'(n < 2));
    chk("ovf",    32'(ovf_n),  32'(m_ovf));
    chk("udf",    32'(udf_n),  32'(m_udf));
    chk("q_norm", 32'(q_n),    32'(m_qn));
    chk("sa_usedw", 32'(uw_s), 32'(n));
    chk("sa_flags", {27'b0, emp_s, full_s, af_s, ae_s, ovf_s | udf_s},
        {27'b0, n == 0, n == 16, n >= 12, n < 2, m_ovf | m_udf});
    if (n > 0) chk("q_sa", 32'(q_sa), 32'(m_q[0]));
  endtask

  initial begin
    srst = 1'b1; wr = 1'b0; rd = 1'b0; din = 8'h00;
    // 1: reset then idle
    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 0);
    // 2: fill, then overflow attempt with 0xAA
    for (int i = 0; i < 16; i++) step(1, 0, 8'(i), 0);
    step(1, 0, 8'hAA, 0);
    // 3: drain, then one underflowing read
    for (int i = 0; i < 16; i++) step(0, 1, 8'h00, 0);
    step(0, 0, 8'h00, 0);
    step(0, 1, 8'h00, 0);
    // 4: full with simultaneous requests, then 40 cycles of both
    step(0, 0, 8'h00, 1);
    for (int i = 0; i < 16; i++) step(1, 0, 8'(8'h40 + i), 0);
    step(1, 1, 8'hEE, 0);
    for (int i = 0; i < 40; i++) step(1, 1, 8'(8'h80 + i), 0);
    // 5: empty with simultaneous requests
    step(0, 0, 8'h00, 1);
    step(1, 1, 8'h55, 0);
    step(0, 0, 8'h00, 0);
    step(0, 1, 8'h00, 0);
    // 6: reset with a write pending, then no stale data
    for (int i = 0; i < 5; i++) step(1, 0, 8'(8'hC0 + i), 0);
    step(1, 0, 8'hDD, 1);
    step(1, 0, 8'h77, 0);
    step(0, 1, 8'h00, 0);
    step(0, 0, 8'h00, 0);
    // random traffic with a drifting write bias so the FIFO visits both ends
    for (int i = 0; i < 600; i++) begin
      int bias;
      bias = ((i / 75) % 2 == 0) ? 75 : 25;
      step($urandom_range(99) < bias, $urandom_range(99) < (100 - bias),
           8'($urandom), $urandom_range(199) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sc_fifo_flags.md
Name: sc_fifo_flags

Overview:
Single-clock FIFO with an internal memory array and registered status flags. It is the single-clock, parametrised successor of the write-pointer/full-flag logic used in the dual-clock FIFO. It adds an empty flag, almost-full and almost-empty thresholds, a full-range used-words count, a selectable showahead read mode, and sticky overflow/underflow error flags. It serves as the general-purpose buffer between streaming stages in one clock domain.

Parameters:
DWIDTH, 8, data word width in bits
AWIDTH, 4, address width; depth = 2**AWIDTH words
SHOWAHEAD, 0, 0 = normal read (data one cycle after rd_req_i), 1 = head word always presented on q_o
ALMOST_FULL_VAL, 12, almost_full_o asserted when usedw_o >= this value (range 1..2**AWIDTH)
ALMOST_EMPTY_VAL, 2, almost_empty_o asserted when usedw_o < this value (range 1..2**AWIDTH)

Ports:
clk_i  in  1  clock, all logic on rising edge
srst_i  in  1  reset, synchronous, active-high
data_i  in  DWIDTH  write data
wr_req_i  in  1  write request
rd_req_i  in  1  read request (read-acknowledge in showahead mode)
q_o  out  DWIDTH  read data
empty_o  out  1  FIFO holds 0 words
full_o  out  1  FIFO holds 2**AWIDTH words
almost_empty_o  out  1  usedw_o < ALMOST_EMPTY_VAL
almost_full_o  out  1  usedw_o >= ALMOST_FULL_VAL
usedw_o  out  AWIDTH+1  stored word count, 0..2**AWIDTH
ovf_o  out  1  sticky: a write was attempted while full
udf_o  out  1  sticky: a read was attempted while empty

Behaviour:
- One clock, clk_i. Reset srst_i is synchronous, active-high. All outputs are registered except q_o in showahead mode.
- Reset values: write pointer 0, read pointer 0, usedw_o 0, empty_o 1, full_o 0, almost_empty_o 1, almost_full_o 0, ovf_o 0, udf_o 0. In normal mode q_o resets to 0.
- Memory contents are not reset. Requests presented during a reset cycle are ignored.
- Reset mid-operation empties the FIFO in one cycle, and the error flags clear.
- Write accept: wr_en = wr_req_i & ~full_o, using the registered full_o.
  - On accept, mem[wr_pntr] <= data_i and wr_pntr increments.
- Read accept: rd_en = rd_req_i & ~empty_o; on accept, rd_pntr increments.
- Pointers are AWIDTH bits and wrap naturally from 2**AWIDTH-1 to 0.
- Count update: usedw_next = usedw_o + wr_en - rd_en, computed at AWIDTH+1 bits.
- Flag update: all flags are registered from usedw_next, so the flags and usedw_o are always mutually consistent in the same cycle.
  - empty_o = (usedw_next == 0)
  - full_o = (usedw_next == 2**AWIDTH)
  - almost_full_o = (usedw_next >= ALMOST_FULL_VAL)
  - almost_empty_o = (usedw_next < ALMOST_EMPTY_VAL)
- Simultaneous write and read:
  - Both accepted: usedw_o unchanged, both pointers advance.
  - When full, only the read is accepted, and the count drops by 1. The next cycle's write is accepted.
  - When empty, only the write is accepted, and the count rises by 1.
  - Same-address write/read cannot occur while both are accepted, because usedw is strictly between 0 and 2**AWIDTH in that case.
- Normal mode (SHOWAHEAD=0):
  - On rd_en, q_o <= mem[rd_pntr] at that edge, so data is valid the cycle after the request.
  - q_o holds its value when there is no rd_en.
- Showahead mode (SHOWAHEAD=1):
  - q_o = mem[rd_pntr], an asynchronous array read.
  - q_o is valid whenever empty_o=0. A word written at edge k is visible on q_o in the cycle after edge k, when empty_o first drops.
  - rd_req_i pops the word; the next word appears the following cycle.
  - q_o is don't-care while empty_o=1.
- Error flags:
  - ovf_o <= 1 when wr_req_i & full_o.
  - udf_o <= 1 when rd_req_i & ~empty_o is false and rd_req_i=1, i.e. rd_req_i & empty_o.
  - Both hold until srst_i. The rejected request has no other effect.
- Latency: a write affects usedw_o and the flags on the next cycle. A read affects them on the next cycle.

Test Plan:
Default params (DWIDTH=8, AWIDTH=4, depth 16).
1. Reset then idle -> empty_o=1, almost_empty_o=1, full_o=0, almost_full_o=0, usedw_o=0, ovf_o=0, udf_o=0.
2. Write 0x00..0x0F in 16 consecutive cycles:
   - almost_empty_o drops after the 2nd write (usedw_o=2).
   - almost_full_o rises after the 12th write.
   - full_o=1 and usedw_o=16 after the 16th write.
   - A 17th write with data 0xAA -> ovf_o=1, usedw_o stays 16, and 0xAA is never read.
3. From full, normal mode, read 16 times -> q_o returns 0x00..0x0F, each one cycle after its request. empty_o=1 after the 16th read. One extra read -> udf_o=1, q_o holds 0x0F.
4. Full FIFO, wr_req_i=rd_req_i=1 for one cycle -> read accepted, write rejected, ovf_o=1, usedw_o=15, full_o=0. Then both held for 40 cycles with incrementing data -> usedw_o stays 15, read data sequence stays in order across multiple pointer wraps.
5. Empty FIFO, wr_req_i=rd_req_i=1 with data 0x55 -> write only, usedw_o=1, udf_o=1. In SHOWAHEAD=1, q_o=0x55 the next cycle with empty_o=0.
6. Load 5 words, assert srst_i for one cycle together with wr_req_i=1 -> next cycle usedw_o=0, empty_o=1, error flags 0. A subsequent write/read returns the new word, not stale data.
